// File: rtl/ysyx_25020037_axi_pkg.sv
// Shared definitions for the core's AXI4 read-path blocks.
// Holds the arbiter state encoding, grant owner codes and the AXI burst and
// response constants.
package ysyx_25020037_axi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    G_IFU = 2'b01,
    G_LSU = 2'b10
  } arb_state_e;

  // Owner code used by the picker and by last_grant.
  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  function automatic logic is_granted(input arb_state_e s);
    return (s == G_IFU) || (s == G_LSU);
  endfunction

endpackage

// File: rtl/ysyx_25020037_arb_pick.sv
// Purpose : combinational winner selection between the IFU and LSU read requests.
// Latency : zero cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
// Ports   : req_ifu/req_lsu request levels, last_grant previous owner, grant chosen owner (1 = LSU).
// Macro   : YSYX_25020037_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module ysyx_25020037_arb_pick
  import ysyx_25020037_axi_pkg::*;
(
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic last_grant,
  output logic grant
);

`ifdef YSYX_25020037_ARB_RR_EN
  // On a tie the master that did not win last time goes first; a lone
  // requester always wins.
  always_comb begin
    grant = GNT_IFU;
    if (req_ifu && req_lsu) begin
      grant = ~last_grant;
    end else if (req_lsu) begin
      grant = GNT_LSU;
    end
  end
`else
  // Fixed priority: any LSU request wins, otherwise the IFU is the pick.
  logic unused_pick_in;
  assign unused_pick_in = req_ifu ^ last_grant;
  assign grant = req_lsu ? GNT_LSU : GNT_IFU;
`endif

endmodule

// File: rtl/ysyx_25020037_axi_rd_arbiter.sv
// Purpose : shares one downstream AXI4 AR/R channel pair between the IFU and the LSU.
// Latency : 1 cycle from arvalid in IDLE to m_arvalid; AR and R routing is combinational while granted.
// Backpressure: m_arready/m_rready pass straight through to and from the granted master; the other master sees arready=0 and rvalid=0.
// Ports   : clk/rst (async, active-high); ifu_ar*/ifu_r* and lsu_ar*/lsu_r* upstream
//           read ports; m_ar*/m_r* downstream master port; busy high while a grant is held.
// Macro   : YSYX_25020037_ARB_RR_EN enables round-robin arbitration (in ysyx_25020037_arb_pick).
module ysyx_25020037_axi_rd_arbiter
  import ysyx_25020037_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  // IFU read port
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [ID_W-1:0]   ifu_arid,
  input  logic [7:0]        ifu_arlen,
  input  logic [2:0]        ifu_arsize,
  input  logic [1:0]        ifu_arburst,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  output logic [ID_W-1:0]   ifu_rid,
  // LSU read port
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [ID_W-1:0]   lsu_arid,
  input  logic [7:0]        lsu_arlen,
  input  logic [2:0]        lsu_arsize,
  input  logic [1:0]        lsu_arburst,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,
  output logic [ID_W-1:0]   lsu_rid,
  // Downstream master port
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [ID_W-1:0]   m_arid,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic [ID_W-1:0]   m_rid,
  output logic              busy
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       pick_grant;

  ysyx_25020037_arb_pick u_pick (
    .req_ifu    (ifu_arvalid),
    .req_lsu    (lsu_arvalid),
    .last_grant (last_grant_q),
    .grant      (pick_grant)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IFU;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic. Only the final R beat frees the channel; the AR
  // handshake, or a master withdrawing arvalid, leaves the grant in place.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (ifu_arvalid || lsu_arvalid) begin
          state_d      = (pick_grant == GNT_LSU) ? G_LSU : G_IFU;
          last_grant_d = pick_grant;
        end
      end
      G_IFU, G_LSU: begin
        if (m_rvalid && m_rready && m_rlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output routing. Everything defaults to zero, so IDLE drives no handshakes and no data.
  always_comb begin
    m_arvalid   = 1'b0;
    m_araddr    = '0;
    m_arid      = '0;
    m_arlen     = '0;
    m_arsize    = '0;
    m_arburst   = '0;
    m_rready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rlast   = 1'b0;
    ifu_rid     = '0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rlast   = 1'b0;
    lsu_rid     = '0;
    busy        = is_granted(state_q);
    unique case (state_q)
      G_IFU: begin
        m_arvalid   = ifu_arvalid;
        m_araddr    = ifu_araddr;
        m_arid      = ifu_arid;
        m_arlen     = ifu_arlen;
        m_arsize    = ifu_arsize;
        m_arburst   = ifu_arburst;
        ifu_arready = m_arready;
        m_rready    = ifu_rready;
        ifu_rvalid  = m_rvalid;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rlast   = m_rlast;
        ifu_rid     = m_rid;
      end
      G_LSU: begin
        m_arvalid   = lsu_arvalid;
        m_araddr    = lsu_araddr;
        m_arid      = lsu_arid;
        m_arlen     = lsu_arlen;
        m_arsize    = lsu_arsize;
        m_arburst   = lsu_arburst;
        lsu_arready = m_arready;
        m_rready    = lsu_rready;
        lsu_rvalid  = m_rvalid;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rlast   = m_rlast;
        lsu_rid     = m_rid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_rd_arbiter.sv
`timescale 1ns/1ps
module tb_ysyx_25020037_axi_rd_arbiter;
  import ysyx_25020037_axi_pkg::*;

`ifdef YSYX_25020037_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  localparam logic [31:0] IFU_A = 32'hA000_0000;
  localparam logic [31:0] LSU_A = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [3:0]  ifu_arid, ifu_rid;
  logic [7:0]  ifu_arlen;
  logic [2:0]  ifu_arsize;
  logic [1:0]  ifu_arburst, ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [3:0]  lsu_arid, lsu_rid;
  logic [7:0]  lsu_arlen;
  logic [2:0]  lsu_arsize;
  logic [1:0]  lsu_arburst, lsu_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0] m_araddr, m_rdata;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        busy;

  always #5 clk = ~clk;

  ysyx_25020037_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .busy(busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t       slv_q[$];      // beats the slave will return, in grant order
  beat_t       exp_ifu[$];    // scoreboard of beats the IFU must receive
  beat_t       exp_lsu[$];
  logic [31:0] exp_addr[$];   // AR addresses in expected grant order
  int          total = 0;
  int          bad   = 0;
  logic        model_last = GNT_IFU;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic pick_model(input logic ri, input logic rl, input logic last);
    if (ri && rl && RR_EN) return ~last;
    return rl;
  endfunction

  // Downstream slave: always ready for AR, returns queued beats one per cycle.
  logic       slv_act;
  logic [3:0] slv_id;
  logic [7:0] slv_len;
  initial begin : slave
    logic ar_hs, r_hs, r_last;
    m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
    slv_act = 1'b0; slv_id = '0; slv_len = '0;
    forever begin
      @(negedge clk);
      ar_hs  = m_arvalid && m_arready;
      r_hs   = m_rvalid && m_rready;
      r_last = m_rlast;
      if (ar_hs) begin
        if (exp_addr.size() == 0) chk("ar_unexp", exp_addr.size(), 1);
        else chk("ar_addr", m_araddr, exp_addr.pop_front());
        slv_id  = m_arid;
        slv_len = m_arlen;
      end
      if (m_rvalid && slv_len == 8'd0) chk("single_rlast", m_rlast, 1);
      @(posedge clk); #1;
      if (rst) begin
        slv_act = 1'b0;
        slv_q.delete();
      end else begin
        if (r_hs) begin
          if (slv_q.size() != 0) slv_q.delete(0);
          if (r_last) slv_act = 1'b0;
        end
        if (ar_hs) slv_act = 1'b1;
      end
      if (slv_act && slv_q.size() != 0) begin
        m_rvalid = 1'b1; m_rdata = slv_q[0].data; m_rresp = slv_q[0].resp;
        m_rlast = slv_q[0].last; m_rid = slv_id;
      end else begin
        m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
      end
    end
  end

  // Scoreboard: every beat delivered upstream is popped and compared.
  beat_t e_i, e_l;
  always @(negedge clk) begin
    if (ifu_rvalid && ifu_rready) begin
      if (exp_ifu.size() == 0) chk("ifu_r_unexp", exp_ifu.size(), 1);
      else begin
        e_i = exp_ifu.pop_front();
        chk("ifu_rdata", ifu_rdata, e_i.data);
        chk("ifu_rresp", ifu_rresp, e_i.resp);
        chk("ifu_rlast", ifu_rlast, e_i.last);
        chk("ifu_rid", ifu_rid, e_i.id);
      end
    end
    if (lsu_rvalid && lsu_rready) begin
      if (exp_lsu.size() == 0) chk("lsu_r_unexp", exp_lsu.size(), 1);
      else begin
        e_l = exp_lsu.pop_front();
        chk("lsu_rdata", lsu_rdata, e_l.data);
        chk("lsu_rresp", lsu_rresp, e_l.resp);
        chk("lsu_rlast", lsu_rlast, e_l.last);
        chk("lsu_rid", lsu_rid, e_l.id);
      end
    end
    chk("r_exclusive", ifu_rvalid && lsu_rvalid, 0);
    chk("ar_exclusive", ifu_arready && lsu_arready, 0);
  end

  task automatic ifu_req(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    int n;
    n = 0;
    @(posedge clk); #1;
    ifu_araddr = a; ifu_arid = id; ifu_arlen = len; ifu_arsize = 3'd2;
    ifu_arburst = (len == 8'd0) ? BURST_FIXED : BURST_INCR; ifu_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!ifu_arready && n < 200);
    if (!ifu_arready) chk("ifu_ar_timeout", n, 0);
    @(posedge clk); #1;
    ifu_arvalid = 1'b0;
  endtask

  task automatic lsu_req(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    int n;
    n = 0;
    @(posedge clk); #1;
    lsu_araddr = a; lsu_arid = id; lsu_arlen = len; lsu_arsize = 3'd2;
    lsu_arburst = (len == 8'd0) ? BURST_FIXED : BURST_INCR; lsu_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!lsu_arready && n < 200);
    if (!lsu_arready) chk("lsu_ar_timeout", n, 0);
    @(posedge clk); #1;
    lsu_arvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while ((busy || exp_ifu.size() != 0 || exp_lsu.size() != 0 || exp_addr.size() != 0) && n < 300);
    chk({tag, "_done"}, busy || exp_ifu.size() != 0 || exp_lsu.size() != 0 || exp_addr.size() != 0, 0);
  endtask

  // Simultaneous single-beat requests; winner order comes from the bench model.
  task automatic both_req(input string tag, input logic [31:0] di, input logic [31:0] dl);
    logic  first;
    beat_t bi, bl;
    int    n;
    first = pick_model(1'b1, 1'b1, model_last);
    bi = '{di, RESP_OKAY, 1'b1, 4'h1};
    bl = '{dl, RESP_OKAY, 1'b1, 4'h2};
    exp_ifu.push_back(bi);
    exp_lsu.push_back(bl);
    if (first == GNT_LSU) begin
      exp_addr.push_back(LSU_A); exp_addr.push_back(IFU_A);
      slv_q.push_back(bl); slv_q.push_back(bi);
    end else begin
      exp_addr.push_back(IFU_A); exp_addr.push_back(LSU_A);
      slv_q.push_back(bi); slv_q.push_back(bl);
    end
    fork
      ifu_req(IFU_A, 4'h1, 8'd0);
      lsu_req(LSU_A, 4'h2, 8'd0);
      begin
        n = 0;
        do begin
          @(negedge clk); n++;
          if (!(first ? (lsu_rvalid && lsu_rlast) : (ifu_rvalid && ifu_rlast)))
            chk({tag, "_loser_arready"}, first ? ifu_arready : lsu_arready, 0);
        end while (!(first ? (lsu_rvalid && lsu_rlast) : (ifu_rvalid && ifu_rlast)) && n < 100);
        @(negedge clk);
        chk({tag, "_gap_arready"}, first ? ifu_arready : lsu_arready, 0);
        @(negedge clk);
        chk({tag, "_regrant_arready"}, first ? ifu_arready : lsu_arready, 1);
      end
    join
    wait_done(tag);
    model_last = ~first;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    rst = 1'b1;
    ifu_arvalid = 0; ifu_araddr = 0; ifu_arid = 0; ifu_arlen = 0; ifu_arsize = 0; ifu_arburst = 0; ifu_rready = 1;
    lsu_arvalid = 0; lsu_araddr = 0; lsu_arid = 0; lsu_arlen = 0; lsu_arsize = 0; lsu_arburst = 0; lsu_rready = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_arready", {ifu_arready, lsu_arready}, 0);
    chk("rst_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_last_grant", dut.last_grant_q, GNT_IFU);
    rst = 1'b0;

    // IFU only, single beat
    exp_addr.push_back(32'h3000_0000);
    slv_q.push_back('{32'h0000_0413, RESP_OKAY, 1'b1, 4'h0});
    exp_ifu.push_back('{32'h0000_0413, RESP_OKAY, 1'b1, 4'h5});
    fork
      ifu_req(32'h3000_0000, 4'h5, 8'd0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_idle_m_arvalid", m_arvalid, 0);
        chk("t1_idle_busy", busy, 0);
        @(negedge clk);
        chk("t1_grant_m_arvalid", m_arvalid, 1);
        chk("t1_grant_arready", ifu_arready, 1);
        chk("t1_grant_busy", busy, 1);
        @(negedge clk);
        chk("t1_beat_rvalid", ifu_rvalid, 1);
        chk("t1_beat_busy", busy, 1);
        @(negedge clk);
        chk("t1_release_busy", busy, 0);
      end
    join
    wait_done("t1");
    model_last = GNT_IFU;

    // Simultaneous requests
    both_req("t2", 32'h0000_1111, 32'h0000_2222);

    // LSU error response, single beat
    exp_addr.push_back(LSU_A);
    slv_q.push_back('{32'hDEAD_BEEF, 2'b10, 1'b1, 4'h0});
    exp_lsu.push_back('{32'hDEAD_BEEF, 2'b10, 1'b1, 4'h3});
    lsu_req(LSU_A, 4'h3, 8'd0);
    wait_done("t3");
    chk("t3_state", dut.state_q, IDLE);
    model_last = GNT_LSU;

    // Simultaneous with last_grant = LSU, then repeated
    both_req("t4a", 32'h0000_3333, 32'h0000_4444);
    both_req("t4b", 32'h0000_5555, 32'h0000_6666);

    // IFU 4-beat burst while LSU is requesting
    exp_addr.push_back(IFU_A);
    exp_addr.push_back(LSU_A);
    for (int i = 1; i <= 4; i++) begin
      slv_q.push_back('{32'h11 * i, RESP_OKAY, i == 4, 4'h0});
      exp_ifu.push_back('{32'h11 * i, RESP_OKAY, i == 4, 4'h7});
    end
    slv_q.push_back('{32'h0000_0099, RESP_OKAY, 1'b1, 4'h0});
    exp_lsu.push_back('{32'h0000_0099, RESP_OKAY, 1'b1, 4'h8});
    fork
      ifu_req(IFU_A, 4'h7, 8'd3);
      begin repeat (2) @(posedge clk); lsu_req(LSU_A, 4'h8, 8'd0); end
      begin
        n = 0;
        do begin
          @(negedge clk); n++;
          chk("t5_lsu_rvalid", lsu_rvalid, 0);
          chk("t5_lsu_arready", lsu_arready, 0);
        end while (!(ifu_rvalid && ifu_rlast) && n < 100);
      end
    join
    wait_done("t5");
    model_last = GNT_LSU;

    // Reset after beat 2 of a 4-beat burst
    exp_addr.push_back(32'hA000_0040);
    for (int i = 5; i <= 8; i++) begin
      slv_q.push_back('{32'h11 * i, RESP_OKAY, i == 8, 4'h0});
      exp_ifu.push_back('{32'h11 * i, RESP_OKAY, i == 8, 4'h9});
    end
    ifu_req(32'hA000_0040, 4'h9, 8'd3);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (exp_ifu.size() > 2 && n < 100);
    chk("t6_two_beats", exp_ifu.size(), 2);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", {m_arvalid, m_rready, ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, busy}, 0);
    chk("t6_rst_addr_data", {m_araddr, ifu_rdata}, 0);
    chk("t6_rst_fields", {m_arid, m_arlen, m_arsize, m_arburst, ifu_rresp, ifu_rlast, ifu_rid}, 0);
    chk("t6_rst_state", dut.state_q, IDLE);
    exp_ifu.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = GNT_IFU;
    exp_addr.push_back(32'h3000_0004);
    slv_q.push_back('{32'h0000_0013, RESP_OKAY, 1'b1, 4'h0});
    exp_ifu.push_back('{32'h0000_0013, RESP_OKAY, 1'b1, 4'hA});
    ifu_req(32'h3000_0004, 4'hA, 8'd0);
    wait_done("t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
